// File: rtl/sim_bus_pkg.sv
// Shared definitions for the simulation MMIO bridge.
// Holds register offsets, the access-target enum and the bridge FSM states.
package sim_bus_pkg;

    localparam logic [11:0] OFF_TX     = 12'h000;
    localparam logic [11:0] OFF_STATUS = 12'h004;
    localparam logic [11:0] OFF_CYC_LO = 12'h008;
    localparam logic [11:0] OFF_CYC_HI = 12'h00C;
    localparam logic [11:0] OFF_EXIT   = 12'h010;

    typedef enum logic {
        TGT_RAM,
        TGT_MMIO
    } target_e;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_STALL
    } state_e;

endpackage

// File: rtl/sim_byte_fifo.sv
// Byte-wide synchronous FIFO used as the console TX queue.
// Ports: clk_i/reset_i (sync, active high), push_i/data_i, pop_i/data_o,
//        full_o, empty_o, level_o (entries held, 0..DEPTH).
module sim_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [7:0]               data_i,
    input  logic                     pop_i,
    output logic [7:0]               data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   LVL_ONE = 1;
    localparam logic [AW:0]   LVL_MAX = DEPTH[AW:0];

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign full_o  = (level_q == LVL_MAX);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rptr_q];

    // A push into a full FIFO is fine when the head leaves the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (do_push) wptr_d = wptr_q + PTR_ONE;
        if (do_pop)  rptr_d = rptr_q + PTR_ONE;
        if (do_push && !do_pop)      level_d = level_q + LVL_ONE;
        else if (do_pop && !do_push) level_d = level_q - LVL_ONE;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/sim_mmio_bridge.sv
// CPU memory-port splitter: RAM pass-through plus an MMIO window with a
// console TX FIFO, 64-bit cycle counter and simulation-exit register.
// Ports: mem_* from the CPU, ram_* to the RAM model, console_* byte stream
//        out to the testbench, sim_done/sim_exit_code, bad_access pulse.
module sim_mmio_bridge
    import sim_bus_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE    = 32'h4000_0000,
    parameter int unsigned MMIO_RD_WAIT = 1,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_rbusy,
    output logic        mem_wbusy,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_wmask,
    output logic        ram_rstrb,
    input  logic [31:0] ram_rdata,
    input  logic        ram_rbusy,
    input  logic        ram_wbusy,
    output logic        console_valid,
    output logic [7:0]  console_data,
    input  logic        console_ready,
    output logic        sim_done,
    output logic [31:0] sim_exit_code,
    output logic        bad_access
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] RD_WAIT_INIT =
        (MMIO_RD_WAIT == 0) ? 4'd0 : 4'(MMIO_RD_WAIT - 1);

    state_e      state_q, state_d;
    target_e     tgt_q, tgt_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] shadow_q, shadow_d;
    logic [7:0]  pend_q, pend_d;
    logic        done_q, done_d;
    logic [31:0] code_q, code_d;
    logic        bad_q, bad_d;
    logic [63:0] cnt_q;

    logic        wr_req, rd_req, is_mmio, idle;
    logic [11:0] off;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  push_data;
    logic [LW-1:0] fifo_level;
    logic [31:0] status_word;

    assign wr_req  = |mem_wmask;
    assign rd_req  = mem_rstrb;
    assign is_mmio = (mem_addr[31:12] == MMIO_BASE[31:12]);
    assign off     = {mem_addr[11:2], 2'b00};
    assign idle    = (state_q == IDLE);

    // RAM sees a request only when the bridge accepts it; a read paired
    // with a write is dropped.
    assign ram_addr  = mem_addr;
    assign ram_wdata = mem_wdata;
    assign ram_wmask = (idle && !is_mmio) ? mem_wmask : 4'b0000;
    assign ram_rstrb = idle && !is_mmio && rd_req && !wr_req;

    assign mem_rdata = (tgt_q == TGT_RAM) ? ram_rdata : rdata_q;
    assign mem_rbusy = (tgt_q == TGT_RAM) ? ram_rbusy : (state_q == RD_WAIT);
    assign mem_wbusy = (tgt_q == TGT_RAM) ? ram_wbusy : (state_q == WR_STALL);

    assign console_valid = !fifo_empty;
    assign fifo_pop      = console_valid && console_ready;
    assign sim_done      = done_q;
    assign sim_exit_code = code_q;
    assign bad_access    = bad_q;

    assign status_word = {16'd0, 8'(fifo_level), 6'd0, fifo_empty, fifo_full};

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        wait_d    = wait_q;
        rdata_d   = rdata_q;
        shadow_d  = shadow_q;
        pend_d    = pend_q;
        done_d    = done_q;
        code_d    = code_q;
        bad_d     = 1'b0;
        fifo_push = 1'b0;
        push_data = mem_wdata[7:0];
        unique case (state_q)
            IDLE: begin
                if (wr_req && rd_req) bad_d = 1'b1;
                if (wr_req || rd_req) tgt_d = is_mmio ? TGT_MMIO : TGT_RAM;
                if (wr_req && is_mmio) begin
                    case (off)
                        OFF_TX: begin
                            if (mem_wmask[0]) begin
                                if (fifo_full && !fifo_pop) begin
                                    state_d = WR_STALL;
                                    pend_d  = mem_wdata[7:0];
                                end else begin
                                    fifo_push = 1'b1;
                                end
                            end
                        end
                        OFF_STATUS, OFF_CYC_LO, OFF_CYC_HI: ;
                        OFF_EXIT: begin
                            if (!done_q) begin
                                done_d = 1'b1;
                                code_d = mem_wdata;
                            end
                        end
                        default: bad_d = 1'b1;
                    endcase
                end else if (rd_req && is_mmio) begin
                    case (off)
                        OFF_TX:     rdata_d = '0;
                        OFF_STATUS: rdata_d = status_word;
                        OFF_CYC_LO: begin
                            rdata_d  = cnt_q[31:0];
                            shadow_d = cnt_q[63:32];
                        end
                        OFF_CYC_HI: rdata_d = shadow_q;
                        OFF_EXIT:   rdata_d = '0;
                        default: begin
                            rdata_d = '0;
                            bad_d   = 1'b1;
                        end
                    endcase
                    if (MMIO_RD_WAIT != 0) begin
                        state_d = RD_WAIT;
                        wait_d  = RD_WAIT_INIT;
                    end
                end
            end
            RD_WAIT: begin
                bad_d = wr_req || rd_req;
                if (wait_q == 4'd0) state_d = IDLE;
                else                wait_d  = wait_q - 4'd1;
            end
            WR_STALL: begin
                bad_d = wr_req || rd_req;
                // FIFO is full here, so a pop always makes room.
                if (fifo_pop) begin
                    fifo_push = 1'b1;
                    push_data = pend_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            tgt_q    <= TGT_RAM;
            wait_q   <= '0;
            rdata_q  <= '0;
            shadow_q <= '0;
            pend_q   <= '0;
            done_q   <= 1'b0;
            code_q   <= '0;
            bad_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            wait_q   <= wait_d;
            rdata_q  <= rdata_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            done_q   <= done_d;
            code_q   <= code_d;
            bad_q    <= bad_d;
            cnt_q    <= cnt_q + 64'd1;
        end
    end

    sim_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (fifo_push),
        .data_i  (push_data),
        .pop_i   (fifo_pop),
        .data_o  (console_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

endmodule
